// File: rtl/sys_reset_sequencer_pkg.sv
// Shared types for the board reset sequencer: FSM state encoding and reset-cause codes.
package sys_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_SDRAM_INIT,
        ST_PERIPH,
        ST_RUN
    } rst_state_t;

    localparam logic [1:0] RST_CAUSE_POR       = 2'd0;
    localparam logic [1:0] RST_CAUSE_LOCK_LOSS = 2'd1;
    localparam logic [1:0] RST_CAUSE_EXTERNAL  = 2'd2;
    localparam logic [1:0] RST_CAUSE_SDRAM_TMO = 2'd3;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sys_reset_sequencer_sync.sv
// Two-flop synchroniser followed by an optional stable-level filter; a new level is
// accepted only after it has differed from the current one for CYCLES consecutive cycles.
module sync_debounce
    import sys_reset_sequencer_pkg::*;
#(
    parameter int   CYCLES      = 1,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {2{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    generate
        if (CYCLES <= 1) begin : g_sync_only
            assign level = sync_q[1];
        end else begin : g_debounce
            localparam int             CW = $clog2(CYCLES);
            localparam logic [CW-1:0]  TC = CW'(CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic          level_q;

            // Any return to the accepted level restarts the stability window.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_q   <= '0;
                    level_q <= RESET_LEVEL;
                end else if (sync_q[1] == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == TC) begin
                    cnt_q   <= '0;
                    level_q <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign level = level_q;
        end
    endgenerate

endmodule

// File: rtl/sys_reset_sequencer.sv
// Board reset sequencer: releases SDRAM, then bus/peripherals, then CPU after PLL lock,
// and re-sequences on lock loss, button press, debugger request or SDRAM init timeout.
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_WAIT_LOCK  | all resets asserted, waiting for synchronised PLL lock
// ST_HOLD       | all resets asserted for POR_CYCLES after lock
// ST_SDRAM_INIT | SDRAM released, waiting for config_done or timeout
// ST_PERIPH     | bus/peripherals released, CPU held for CPU_DELAY cycles
// ST_RUN        | everything released
module sys_reset_sequencer
    import sys_reset_sequencer_pkg::*;
#(
    parameter int POR_CYCLES      = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SDRAM_TIMEOUT   = 1000000,
    parameter int CPU_DELAY       = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       button_n,
    input  logic       dbg_reset_req,
    input  logic       sdram_config_done,
    output logic       sdram_reset,
    output logic       sys_reset,
    output logic       cpu_reset,
    output logic [1:0] reset_cause
);

    localparam int            CNT_MAX  = max4(POR_CYCLES, DEBOUNCE_CYCLES, SDRAM_TIMEOUT, CPU_DELAY);
    localparam int            CW       = $clog2(CNT_MAX);
    localparam logic [CW-1:0] POR_TC   = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] SDRAM_TC = CW'(SDRAM_TIMEOUT - 1);
    localparam logic [CW-1:0] CPU_TC   = CW'(CPU_DELAY - 1);

    rst_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    cause_d;
    logic          restart;
    logic          sdram_d, sys_d, cpu_d;
    logic          locked_s;
    logic          btn_level;
    logic          btn_prev_q;
    logic          btn_press;

    sync_debounce #(
        .CYCLES      (1),
        .RESET_LEVEL (1'b0)
    ) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (pll_locked),
        .level   (locked_s)
    );

    sync_debounce #(
        .CYCLES      (DEBOUNCE_CYCLES),
        .RESET_LEVEL (1'b1)
    ) u_button_db (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (button_n),
        .level   (btn_level)
    );

    // Only the falling edge of the accepted level counts, so a held button fires once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_prev_q <= 1'b1;
        end else begin
            btn_prev_q <= btn_level;
        end
    end

    assign btn_press = btn_prev_q & ~btn_level;

    always_comb begin
        state_d = state_q;
        cause_d = reset_cause;
        restart = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == POR_TC) state_d = ST_SDRAM_INIT;
            end
            ST_SDRAM_INIT: begin
                if (sdram_config_done) begin
                    state_d = ST_PERIPH;
                end else if (cnt_q == SDRAM_TC) begin
                    state_d = ST_HOLD;
                    cause_d = RST_CAUSE_SDRAM_TMO;
                end
            end
            ST_PERIPH: begin
                if (cnt_q == CPU_TC) state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase

        // Aborts override normal progress; restart also covers re-entry of the same state.
        if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            restart = 1'b1;
            if (state_q != ST_WAIT_LOCK) cause_d = RST_CAUSE_LOCK_LOSS;
        end else if (btn_press || dbg_reset_req) begin
            state_d = ST_HOLD;
            cause_d = RST_CAUSE_EXTERNAL;
            restart = 1'b1;
        end

        sdram_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_HOLD);
        sys_d   = sdram_d || (state_d == ST_SDRAM_INIT);
        cpu_d   = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT_LOCK;
            sdram_reset <= 1'b1;
            sys_reset   <= 1'b1;
            cpu_reset   <= 1'b1;
            reset_cause <= RST_CAUSE_POR;
        end else begin
            state_q     <= state_d;
            sdram_reset <= sdram_d;
            sys_reset   <= sys_d;
            cpu_reset   <= cpu_d;
            reset_cause <= cause_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (restart || (state_d != state_q)) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Scoreboard bench: each stimulus step queues the output changes it should cause
// (value and edge number); a negedge monitor pops and compares on every output change.
module tb_sys_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       button_n;
    logic       dbg_reset_req;
    logic       sdram_config_done;
    logic       sdram_reset;
    logic       sys_reset;
    logic       cpu_reset;
    logic [1:0] reset_cause;

    typedef struct {
        logic [4:0] val;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_bad = 0;
    logic       mon_en = 1'b0;
    logic [4:0] obs;
    logic [4:0] last_obs = 5'b11100;

    sys_reset_sequencer #(
        .POR_CYCLES      (10),
        .DEBOUNCE_CYCLES (8),
        .SDRAM_TIMEOUT   (50),
        .CPU_DELAY       (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pll_locked        (pll_locked),
        .button_n          (button_n),
        .dbg_reset_req     (dbg_reset_req),
        .sdram_config_done (sdram_config_done),
        .sdram_reset       (sdram_reset),
        .sys_reset         (sys_reset),
        .cpu_reset         (cpu_reset),
        .reset_cause       (reset_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic exp_out(input int c, input logic sd, input logic sy, input logic cp,
                           input logic [1:0] cause);
        exp_t x;
        x.val = {sd, sy, cp, cause};
        x.cyc = c;
        sb_q.push_back(x);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            obs = {sdram_reset, sys_reset, cpu_reset, reset_cause};
            if (obs != last_obs) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_change", int'(obs), int'(last_obs));
                end else begin
                    e = sb_q.pop_front();
                    chk("out_value", int'(obs), int'(e.val));
                    chk("out_cycle", cyc, e.cyc);
                end
                last_obs = obs;
            end
        end
    end

    initial begin
        int d, m, n, r, s, h;
        reset_n           = 1'b0;
        pll_locked        = 1'b0;
        button_n          = 1'b1;
        dbg_reset_req     = 1'b0;
        sdram_config_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sdram", int'(sdram_reset), 1);
        chk("rst_sys",   int'(sys_reset),   1);
        chk("rst_cpu",   int'(cpu_reset),   1);
        chk("rst_cause", int'(reset_cause), 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // power-on: lock 5 cycles after reset, config_done 3 cycles into SDRAM_INIT
        wait_cyc(cyc + 5);
        pll_locked = 1'b1;
        s = cyc + 13;
        exp_out(s, 0, 1, 1, 2'd0);
        wait_cyc(s + 2);
        sdram_config_done = 1'b1;
        exp_out(s + 3, 0, 0, 1, 2'd0);
        exp_out(s + 7, 0, 0, 0, 2'd0);
        wait_cyc(s + 12);

        // one-cycle lock drop in RUN
        n = cyc;
        pll_locked = 1'b0;
        exp_out(n + 3, 1, 1, 1, 2'd1);
        @(negedge clk);
        pll_locked = 1'b1;
        r = cyc;
        exp_out(r + 13, 0, 1, 1, 2'd1);
        exp_out(r + 14, 0, 0, 1, 2'd1);
        exp_out(r + 18, 0, 0, 0, 2'd1);
        wait_cyc(r + 25);

        // bouncing button, then a real hold
        for (int k = 0; k < 24; k++) begin
            button_n = ((k / 3) % 2) == 1;
            @(negedge clk);
        end
        m = cyc;
        button_n = 1'b0;
        h = m + 11;
        exp_out(h, 1, 1, 1, 2'd2);
        exp_out(h + 10, 0, 1, 1, 2'd2);
        exp_out(h + 11, 0, 0, 1, 2'd2);
        exp_out(h + 15, 0, 0, 0, 2'd2);
        wait_cyc(m + 12);
        button_n = 1'b1;
        wait_cyc(h + 25);

        // SDRAM timeout twice, then config_done
        sdram_config_done = 1'b0;
        d = cyc;
        dbg_reset_req = 1'b1;
        exp_out(d + 1, 1, 1, 1, 2'd2);
        @(negedge clk);
        dbg_reset_req = 1'b0;
        exp_out(d + 11,  0, 1, 1, 2'd2);
        exp_out(d + 61,  1, 1, 1, 2'd3);
        exp_out(d + 71,  0, 1, 1, 2'd3);
        exp_out(d + 121, 1, 1, 1, 2'd3);
        exp_out(d + 131, 0, 1, 1, 2'd3);
        wait_cyc(d + 133);
        sdram_config_done = 1'b1;
        exp_out(d + 134, 0, 0, 1, 2'd3);
        exp_out(d + 138, 0, 0, 0, 2'd3);
        wait_cyc(d + 145);

        // debugger request in PERIPH, then again mid-HOLD to restart the count
        d = cyc;
        dbg_reset_req = 1'b1;
        exp_out(d + 1, 1, 1, 1, 2'd2);
        @(negedge clk);
        dbg_reset_req = 1'b0;
        exp_out(d + 11, 0, 1, 1, 2'd2);
        exp_out(d + 12, 0, 0, 1, 2'd2);
        wait_cyc(d + 13);
        dbg_reset_req = 1'b1;
        exp_out(d + 14, 1, 1, 1, 2'd2);
        @(negedge clk);
        dbg_reset_req = 1'b0;
        wait_cyc(d + 18);
        dbg_reset_req = 1'b1;
        @(negedge clk);
        dbg_reset_req = 1'b0;
        exp_out(d + 29, 0, 1, 1, 2'd2);
        exp_out(d + 30, 0, 0, 1, 2'd2);
        exp_out(d + 34, 0, 0, 0, 2'd2);
        wait_cyc(d + 40);

        // reset_n mid-SDRAM_INIT together with lock loss and button press
        sdram_config_done = 1'b0;
        d = cyc;
        dbg_reset_req = 1'b1;
        exp_out(d + 1, 1, 1, 1, 2'd2);
        @(negedge clk);
        dbg_reset_req = 1'b0;
        exp_out(d + 11, 0, 1, 1, 2'd2);
        wait_cyc(d + 14);
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        button_n   = 1'b0;
        exp_out(d + 15, 1, 1, 1, 2'd0);
        wait_cyc(d + 16);
        reset_n = 1'b1;
        wait_cyc(d + 40);
        button_n = 1'b1;
        wait_cyc(d + 60);
        sdram_config_done = 1'b1;
        r = cyc;
        pll_locked = 1'b1;
        exp_out(r + 13, 0, 1, 1, 2'd0);
        exp_out(r + 14, 0, 0, 1, 2'd0);
        exp_out(r + 18, 0, 0, 0, 2'd0);
        wait_cyc(r + 25);

        // lock loss and button press landing on the same edge: lock wins
        m = cyc;
        button_n = 1'b0;
        wait_cyc(m + 8);
        pll_locked = 1'b0;
        exp_out(m + 11, 1, 1, 1, 2'd1);
        wait_cyc(m + 14);
        button_n = 1'b1;
        wait_cyc(m + 30);
        r = cyc;
        pll_locked = 1'b1;
        exp_out(r + 13, 0, 1, 1, 2'd1);
        exp_out(r + 14, 0, 0, 1, 2'd1);
        exp_out(r + 18, 0, 0, 0, 2'd1);
        wait_cyc(r + 25);

        chk("sb_left",     sb_q.size(),        0);
        chk("final_cpu",   int'(cpu_reset),    0);
        chk("final_cause", int'(reset_cause),  1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
